// File: rtl/attn_sched_pkg.sv
// attn_sched_pkg: shared FSM state encoding and requester indices for the matmul engine arbiter
package attn_sched_pkg;
  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;
  localparam int REQ_QKV = 0;
  localparam int REQ_QK  = 1;
  localparam int REQ_AV  = 2;
  localparam int REQ_MLP = 3;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search starting at ptr, wrapping modulo NUM_REQ
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      idx,
  output logic               found
);
  logic [IW-1:0] j;
  // scan from the farthest offset back to ptr so the nearest set bit at or after ptr wins
  always_comb begin
    found = |req;
    idx = '0;
    j = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % NUM_REQ);
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/mm_engine_arbiter.sv
// mm_engine_arbiter: round-robin arbiter granting one requester at a time to the shared matmul engine
module mm_engine_arbiter
  import attn_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W = 16,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic [NUM_REQ-1:0] req_done,
  output logic               req_err,
  output logic               eng_start,
  input  logic               eng_done,
  output logic               eng_abort,
  output logic               busy
);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] req_q, req_d, grant_q, grant_d;
  logic [IW-1:0] gidx_q, gidx_d, ptr_q, ptr_d, win;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d, found;
  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req(req_q),
    .ptr(ptr_q),
    .idx(win),
    .found(found)
  );
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q <= '0;
      grant_q <= '0;
      gidx_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      grant_q <= grant_d;
      gidx_q <= gidx_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  // next-state: requests are registered before arbitration; the finishing owner is masked so its trailing req is not re-granted
  always_comb begin
    state_d = state_q;
    req_d = req & ~(state_q == DONE ? grant_q : '0);
    grant_d = grant_q;
    gidx_d = gidx_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    eng_abort = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        state_d = START;
        grant_d = NUM_REQ'(1) << win;
        gidx_d = win;
      end
      START: begin
        state_d = BUSY;
        cnt_d = '0;
        err_d = 1'b0;
      end
      BUSY: if (eng_done) begin
        state_d = DONE;
        err_d = 1'b0;
      end else if (cnt_q == TERM) begin
        state_d = DONE;
        err_d = 1'b1;
        eng_abort = 1'b1;
      end else cnt_d = cnt_q + CNT_W'(1);
      DONE: begin
        state_d = IDLE;
        ptr_d = gidx_q == IW'(NUM_REQ - 1) ? '0 : gidx_q + IW'(1);
        grant_d = '0;
        gidx_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign grant = grant_q;
  assign grant_idx = gidx_q;
  assign req_done = state_q == DONE ? grant_q : '0;
  assign req_err = state_q == DONE && err_q;
  assign eng_start = state_q == START;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_mm_engine_arbiter.sv
// tb_mm_engine_arbiter: directed vector table plus hand sequences for contention, wrap, timeout and reset
module tb_mm_engine_arbiter;
  typedef struct {
    logic rst;
    logic [3:0] req;
    logic done;
    logic [3:0] g;
    logic [1:0] gi;
    logic [3:0] rd;
    logic re, es, ea, bz;
  } vec_t;
  logic clk = 0, rst = 1, eng_done = 0, eng_done_t = 0;
  logic [3:0] req = 0, req_t = 0;
  logic [3:0] grant, req_done, grant_t, req_done_t;
  logic [1:0] grant_idx, grant_idx_t;
  logic req_err, eng_start, eng_abort, busy;
  logic req_err_t, eng_start_t, eng_abort_t, busy_t;
  int nchk = 0, nerr = 0, cyc = 0;
  vec_t tv[17];
  mm_engine_arbiter u_dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .grant_idx(grant_idx),
    .req_done(req_done), .req_err(req_err), .eng_start(eng_start),
    .eng_done(eng_done), .eng_abort(eng_abort), .busy(busy)
  );
  mm_engine_arbiter #(.TIMEOUT(8)) u_tmo (
    .clk(clk), .rst(rst), .req(req_t), .grant(grant_t), .grant_idx(grant_idx_t),
    .req_done(req_done_t), .req_err(req_err_t), .eng_start(eng_start_t),
    .eng_done(eng_done_t), .eng_abort(eng_abort_t), .busy(busy_t)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end by itself");
    $fatal(1);
  end
  function automatic vec_t mk(logic r, logic [3:0] rq, logic d, logic [3:0] g, logic [1:0] gi,
                              logic [3:0] rd, logic re, logic es, logic ea, logic bz);
    vec_t v;
    v.rst = r; v.req = rq; v.done = d; v.g = g; v.gi = gi;
    v.rd = rd; v.re = re; v.es = es; v.ea = ea; v.bz = bz;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_start(input bit tmo, output int s);
    s = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((tmo ? eng_start_t : eng_start) === 1'b1) begin
        s = cyc;
        break;
      end
    end
    if (s < 0) begin
      nchk++;
      nerr++;
      $display("FAIL start_wait: got no eng_start expected one within 40 cycles");
    end
  endtask
  task automatic do_op(input int exp_idx, input int lat, output int s);
    wait_start(0, s);
    chk("grant_idx", grant_idx, exp_idx);
    chk("grant", grant, 32'd1 << exp_idx);
    repeat (lat) @(posedge clk);
    #1 eng_done = 1;
    @(posedge clk);
    #1 eng_done = 0;
    @(negedge clk);
    chk("op_done", {req_done, req_err}, {4'(32'd1 << exp_idx), 1'b0});
  endtask
  initial begin
    int s, prev, ab;
    tv[0] = mk(1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    tv[1] = mk(0, 4'b0001, 0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    tv[2] = mk(0, 4'b0001, 0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    tv[3] = mk(0, 4'b0001, 0, 4'b0001, 0, 4'b0000, 0, 1, 0, 1);
    for (int i = 4; i <= 11; i++) tv[i] = mk(0, 4'b0001, i == 11, 4'b0001, 0, 4'b0000, 0, 0, 0, 1);
    tv[12] = mk(0, 4'b0001, 0, 4'b0001, 0, 4'b0001, 0, 0, 0, 1);
    tv[13] = mk(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    tv[14] = mk(0, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    tv[15] = mk(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    tv[16] = mk(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      #1 rst = tv[i].rst; req = tv[i].req; eng_done = tv[i].done;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {grant, grant_idx, req_done, req_err, eng_start, eng_abort, busy},
          {tv[i].g, tv[i].gi, tv[i].rd, tv[i].re, tv[i].es, tv[i].ea, tv[i].bz});
    end
    eng_done = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0; req = 4'b1111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      do_op(k % 4, 5, s);
      if (k > 0) chk("start_spacing", s - prev, 8);
      prev = s;
    end
    wait_start(0, s);
    chk("post_wrap_idx", grant_idx, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_busy_outs", {grant, grant_idx, req_done, req_err, eng_start, eng_abort, busy}, 0);
    @(negedge clk);
    chk("rst_no_done", {req_done, eng_abort}, 0);
    do_op(0, 5, s);
    req = 4'b0000;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0; req = 4'b0100;
    do_op(2, 3, s);
    req = 4'b0101;
    do_op(0, 3, s);
    do_op(2, 3, s);
    req = 4'b0000;
    req_t = 4'b0010;
    wait_start(1, s);
    chk("tmo_grant_idx", grant_idx_t, 1);
    ab = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (eng_abort_t) begin
        ab = n;
        break;
      end
    end
    chk("abort_delay", ab, 8);
    @(negedge clk);
    chk("tmo_done_err", {req_done_t, req_err_t}, {4'b0010, 1'b1});
    req_t = 4'b1000;
    wait_start(1, s);
    chk("coin_grant_idx", grant_idx_t, 3);
    repeat (8) @(posedge clk);
    #1 eng_done_t = 1;
    @(negedge clk);
    chk("coin_no_abort", eng_abort_t, 0);
    @(posedge clk);
    #1 eng_done_t = 0;
    @(negedge clk);
    chk("coin_done_noerr", {req_done_t, req_err_t}, {4'b1000, 1'b0});
    req_t = 4'b0000;
    repeat (3) @(negedge clk);
    chk("idle_after", {busy, busy_t}, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
